// File: rtl/bram_stream_reader_pkg.sv
// Shared types and constants for the BRAM stream reader and its output buffer.
package bram_stream_reader_pkg;

    // Transfer sequencing states of the reader
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Output buffer depth; also the cap on words buffered plus in flight
    localparam int BUF_DEPTH = 2;

    // Width of the buffer occupancy count (holds 0..BUF_DEPTH)
    localparam int BUF_CNT_W = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/bram_stream_reader_stream_buf2.sv
// stream_buf2: two-entry valid/ready buffer with a fall-through path.
// A word pushed while the buffer is empty appears on the stream output in the
// same cycle, so a word returned by the RAM can be consumed with no extra stage.
// Words that are not consumed straight away are held in order until popped.
module stream_buf2
    import bram_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [BUF_CNT_W-1:0]  count_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i
);

    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [BUF_CNT_W-1:0]  count_q, count_d;
    logic                  rdPtr_q, rdPtr_d;
    logic                  wrPtr_q, wrPtr_d;
    logic                  empty;
    logic                  pop;
    logic                  store;
    logic                  popMem;

    assign empty     = (count_q == '0);
    assign m_valid_o = !empty || push_i;
    assign m_data_o  = !empty ? mem_q[rdPtr_q] : (push_i ? data_i : '0);
    assign pop       = m_valid_o && m_ready_i;
    assign count_o   = count_q;

    // Decide whether the incoming word is stored or bypasses, and advance pointers
    always_comb begin
        store   = push_i && !(empty && pop);
        popMem  = pop && !empty;
        count_d = count_q + BUF_CNT_W'(store) - BUF_CNT_W'(popMem);
        rdPtr_d = popMem ? ~rdPtr_q : rdPtr_q;
        wrPtr_d = store  ? ~wrPtr_q : wrPtr_q;
    end

    // Buffer storage, occupancy and pointers; flush drops everything held
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            count_q <= '0;
            rdPtr_q <= 1'b0;
            wrPtr_q <= 1'b0;
        end else if (flush_i) begin
            count_q <= '0;
            rdPtr_q <= 1'b0;
            wrPtr_q <= 1'b0;
        end else begin
            if (store) begin
                mem_q[wrPtr_q] <= data_i;
            end
            count_q <= count_d;
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
        end
    end

endmodule

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: walks an address range of a synchronous-read block RAM
// and streams the words out over valid/ready with full backpressure.
// Reads are only issued while buffered plus in-flight words stay below the
// output buffer depth, so nothing returned by the RAM can ever be dropped.
// Optional feature macro: BRAM_STREAM_READER_ABORT_EN adds an abort input that
// cancels a running transfer and discards any words not yet delivered.
module bram_stream_reader
    import bram_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   len,
`ifdef BRAM_STREAM_READER_ABORT_EN
    input  logic                  abort,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] r_addr,
    input  logic [DATA_WIDTH-1:0] r_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last
);

    localparam logic [ADDR_WIDTH:0] LEN_ONE = 1;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] rAddr_q, rAddr_d;
    logic [ADDR_WIDTH:0]   rdLeft_q, rdLeft_d;
    logic [ADDR_WIDTH:0]   beatLeft_q, beatLeft_d;
    logic                  inFlight_q, inFlight_d;
    logic [BUF_CNT_W-1:0]  bufCount;
    logic [2:0]            level;
    logic                  pop;
    logic                  issue;
    logic                  abortReq;

`ifdef BRAM_STREAM_READER_ABORT_EN
    assign abortReq = abort && ((state_q == READ) || (state_q == DRAIN));
`else
    assign abortReq = 1'b0;
`endif

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign r_addr = rAddr_q;
    assign pop    = m_valid && m_ready;
    assign m_last = m_valid && (beatLeft_q == LEN_ONE);

    // Words that will still be held after this cycle's pop; a read may only
    // be issued when that leaves room for the word it brings back
    assign level = 3'(bufCount) + 3'(inFlight_q) - 3'(pop);
    assign issue = (state_q == READ) && (rdLeft_q != '0)
                   && (level < 3'(BUF_DEPTH)) && !abortReq;

    // Next-state, address walk and word/beat bookkeeping
    always_comb begin
        state_d    = state_q;
        rAddr_d    = rAddr_q;
        rdLeft_d   = rdLeft_q;
        beatLeft_d = beatLeft_q;
        inFlight_d = issue;

        case (state_q)
            IDLE: begin
                if (start) begin
                    rAddr_d    = base_addr;
                    rdLeft_d   = len;
                    beatLeft_d = len;
                    // An empty transfer idles one cycle in DRAIN so its done
                    // pulse lands where the first beat would have appeared
                    state_d    = (len != '0) ? READ : DRAIN;
                end
            end
            READ: begin
                if (issue && (rdLeft_q == LEN_ONE)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if ((beatLeft_q == '0) || (pop && (beatLeft_q == LEN_ONE))) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (issue) begin
            rAddr_d  = rAddr_q + 1'b1;
            rdLeft_d = rdLeft_q - 1'b1;
        end
        if (pop) begin
            beatLeft_d = beatLeft_q - 1'b1;
        end
        if (abortReq) begin
            state_d    = DONE;
            inFlight_d = 1'b0;
        end
    end

    // State and counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rAddr_q    <= '0;
            rdLeft_q   <= '0;
            beatLeft_q <= '0;
            inFlight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rAddr_q    <= rAddr_d;
            rdLeft_q   <= rdLeft_d;
            beatLeft_q <= beatLeft_d;
            inFlight_q <= inFlight_d;
        end
    end

    stream_buf2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush_i   (abortReq),
        .push_i    (inFlight_q),
        .data_i    (r_data),
        .count_o   (bufCount),
        .m_data_o  (m_data),
        .m_valid_o (m_valid),
        .m_ready_i (m_ready)
    );

endmodule

// File: tb/tb_bram_stream_reader.sv
// Testbench for bram_stream_reader with a 16-word RAM holding 8'hA0+i.
// Expected beats come from a queue built by plain address arithmetic over the
// RAM contents; handshakes, stalls, last-beat flag and done timing are checked.
module tb_bram_stream_reader;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   len;
    logic          busy;
    logic          done;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
`ifdef BRAM_STREAM_READER_ABORT_EN
    logic          abort;
`endif

    int checks;
    int errors;

    logic [DW-1:0] ramModel [DEPTH];
    bit            readyPat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    typedef struct {
        int base;
        int lenW;
        int mode;
        int expFirst;
    } vec_t;

    vec_t vecs [7];

    bram_stream_reader #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
`ifdef BRAM_STREAM_READER_ABORT_EN
        .abort     (abort),
`endif
        .busy      (busy),
        .done      (done),
        .r_addr    (r_addr),
        .r_data    (r_data),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM with one cycle of latency
    always @(posedge clk) begin
        r_data <= ramModel[r_addr];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
        end
    endtask

    function automatic bit readyFor(input int mode, input int n);
        if (mode == 0) return 1'b1;
        if (mode == 1) return readyPat[n % 6];
        return 1'($urandom_range(0, 1));
    endfunction

    // Runs one transfer. mode: 0 ready always, 1 fixed toggle pattern, 2 random.
    // restartAt pulses start while busy; stopAfter ends the run after that many
    // beats by reset (stopKind 0) or abort (stopKind 1).
    task automatic applyStimulus(input int base, input int lenW, input int mode, input int expFirst,
                                 input int restartAt, input int stopAfter, input int stopKind);
        logic [DW-1:0] expQ [$];
        logic [DW-1:0] prevData;
        int  n, beatIdx, lastN, firstN, expDone;
        bit  prevValid, prevHs, finished;

        for (int i = 0; i < lenW; i++) begin
            expQ.push_back(ramModel[(base + i) % DEPTH]);
        end
        @(negedge clk);
        start     = 1'b1;
        base_addr = AW'(base);
        len       = (AW+1)'(lenW);
        m_ready   = 1'b0;
        @(negedge clk);
        n = 0; beatIdx = 0; lastN = -1; firstN = -1;
        prevValid = 1'b0; prevHs = 1'b0; finished = 1'b0; prevData = '0;

        while (!finished && n < 200) begin
            m_ready = readyFor(mode, n);
            start   = (n == restartAt);
            if (start) begin
                base_addr = AW'(base + 5);
                len       = (AW+1)'(2);
            end
            #1;
            if (n == 0) checkOutput("busy after start", busy, 1);
            if (mode == 0 && n < lenW) checkOutput("r_addr walk", r_addr, (base + n) % DEPTH);
            if (prevValid && !prevHs) begin
                checkOutput("valid held in stall", m_valid, 1);
                checkOutput("data held in stall", m_data, prevData);
            end
            if (m_valid) begin
                if (firstN < 0) firstN = n;
                if (beatIdx >= lenW) begin
                    checkOutput("extra beat", m_valid, 0);
                end else if (m_ready) begin
                    checkOutput("beat data", m_data, expQ[beatIdx]);
                    checkOutput("beat last", m_last, (beatIdx == lenW - 1) ? 1 : 0);
                    if (beatIdx == 0 && expFirst >= 0) checkOutput("first word", m_data, expFirst);
                    beatIdx++;
                    if (beatIdx == lenW) lastN = n;
                    if (beatIdx == stopAfter) begin
                        if (stopKind == 0) begin
                            @(posedge clk);
                            #2 reset_n = 1'b0;
                            #1;
                            checkOutput("reset m_valid", m_valid, 0);
                            checkOutput("reset busy", busy, 0);
                            checkOutput("reset done", done, 0);
                            checkOutput("reset r_addr", r_addr, 0);
                            @(negedge clk);
                            reset_n = 1'b1;
                        end else begin
`ifdef BRAM_STREAM_READER_ABORT_EN
                            abort = 1'b1;
                            @(negedge clk);
                            abort   = 1'b0;
                            m_ready = 1'b1;
                            #1;
                            checkOutput("abort m_valid", m_valid, 0);
                            checkOutput("abort done", done, 1);
                            @(negedge clk);
                            #1;
                            checkOutput("abort busy", busy, 0);
                            checkOutput("abort done clear", done, 0);
                            checkOutput("abort no valid", m_valid, 0);
`endif
                        end
                        return;
                    end
                end
            end
            if (done) begin
                expDone = (lenW == 0) ? 1 : lastN + 1;
                checkOutput("done timing", n, expDone);
                finished = 1'b1;
            end
            prevValid = m_valid;
            prevHs    = m_valid && m_ready;
            prevData  = m_data;
            @(negedge clk);
            n++;
        end
        start = 1'b0;

        if (!finished) checkOutput("done timeout", 0, 1);
        checkOutput("beat count", beatIdx, lenW);
        checkOutput("first valid cycle", firstN, (lenW == 0) ? -1 : 1);
        if (mode == 0 && lenW > 0) checkOutput("back-to-back beats", lastN, lenW);
        #1;
        checkOutput("busy cleared", busy, 0);
        checkOutput("done single pulse", done, 0);
        if (restartAt >= 0) begin
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                #1;
                checkOutput("no second transfer valid", m_valid, 0);
                checkOutput("no second transfer busy", busy, 0);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < DEPTH; i++) ramModel[i] = 8'hA0 + 8'(i);

        vecs[0] = '{base: 2,  lenW: 4,  mode: 0, expFirst: 'hA2};
        vecs[1] = '{base: 14, lenW: 4,  mode: 0, expFirst: 'hAE};
        vecs[2] = '{base: 0,  lenW: 6,  mode: 1, expFirst: 'hA0};
        vecs[3] = '{base: 0,  lenW: 0,  mode: 0, expFirst: -1};
        vecs[4] = '{base: 15, lenW: 16, mode: 0, expFirst: 'hAF};
        vecs[5] = '{base: 7,  lenW: 1,  mode: 1, expFirst: 'hA7};
        vecs[6] = '{base: 9,  lenW: 16, mode: 2, expFirst: 'hA9};

        reset_n   = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        len       = '0;
        m_ready   = 1'b0;
`ifdef BRAM_STREAM_READER_ABORT_EN
        abort     = 1'b0;
`endif
        #12;
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset m_valid", m_valid, 0);
        checkOutput("reset m_last", m_last, 0);
        checkOutput("reset r_addr", r_addr, 0);
        checkOutput("reset m_data", m_data, 0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int v = 0; v < 7; v++) begin
            applyStimulus(vecs[v].base, vecs[v].lenW, vecs[v].mode, vecs[v].expFirst, -1, -1, 0);
        end

        $display("[TB] start pulses while busy");
        applyStimulus(0, 0, 0, -1, 0, -1, 0);
        applyStimulus(4, 3, 0, 'hA4, 1, -1, 0);

        $display("[TB] reset mid-transfer then fresh transfer");
        applyStimulus(0, 8, 0, 'hA0, -1, 3, 0);
        applyStimulus(5, 5, 1, 'hA5, -1, -1, 0);

`ifdef BRAM_STREAM_READER_ABORT_EN
        $display("[TB] abort mid-transfer then fresh transfer");
        applyStimulus(0, 8, 0, 'hA0, -1, 2, 1);
        applyStimulus(3, 3, 0, 'hA3, -1, -1, 0);
`endif

        $display("[TB] random transfers");
        for (int r = 0; r < 12; r++) begin
            int rb;
            int rl;
            rb = int'($urandom_range(0, DEPTH - 1));
            rl = int'($urandom_range(0, DEPTH));
            applyStimulus(rb, rl, 2, -1, -1, -1, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
